// File: rtl/lsp_dec_pkg.sv
// Shared constants and types for the G.729 LSP decoder stages.
package lsp_dec_pkg;

  localparam int unsigned M     = 10;  // LSP order (words per row)
  localparam int unsigned MA_NP = 4;   // MA predictor rows in freq_prev

  localparam int unsigned KW = $clog2(MA_NP);
  localparam int unsigned IW = $clog2(M);

  // freq_prev[k][i] lives at FREQ_PREV_BASE + k*M + i
  localparam logic [11:0] FREQ_PREV_BASE = 12'd0;
  localparam logic [11:0] LSP_ELE_BASE   = 12'd64;

  localparam logic [KW-1:0] K_FIRST = KW'(MA_NP - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(M - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StDone
  } lsp_prev_state_e;

endpackage

// File: rtl/lsp_prev_addr_gen.sv
// Maps (row, index) pairs to scratch addresses for the freq_prev history shift.
// Row 0 reads from lsp_ele; every other row reads from the row below it.
module lsp_prev_addr_gen
  import lsp_dec_pkg::*;
(
  input  logic [KW-1:0] rd_k,
  input  logic [IW-1:0] rd_i,
  input  logic [KW-1:0] wr_k,
  input  logic [IW-1:0] wr_i,
  output logic [11:0]   rd_addr,
  output logic [11:0]   wr_addr
);

  logic [11:0] rd_row;

  // Source and destination address arithmetic
  always_comb begin
    if (rd_k == '0) begin
      rd_row = LSP_ELE_BASE;
    end else begin
      rd_row = FREQ_PREV_BASE + 12'(rd_k - KW'(1)) * 12'(M);
    end
    rd_addr = rd_row + 12'(rd_i);
    wr_addr = FREQ_PREV_BASE + 12'(wr_k) * 12'(M) + 12'(wr_i);
  end

endmodule

// File: rtl/lsp_prev_update.sv
// G.729 Lsp_prev_update: shifts the freq_prev MA history one row up and inserts lsp_ele
// as row 0, entirely through the scratch-memory port.
// Optional macro LSP_PREV_UPDATE_PIPE_EN selects a streaming one-word-per-cycle copy;
// by default a 3-cycle-per-word READ/WAIT/WRITE sequence is used.
module lsp_prev_update
  import lsp_dec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] memIn,
  output logic [11:0] memReadAddr,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        done
);

  lsp_prev_state_e state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic [KW-1:0]   wr_k;
  logic [IW-1:0]   wr_i;
  logic [11:0]     rd_addr, wr_addr;
  logic            last_word;

`ifdef LSP_PREV_UPDATE_PIPE_EN
  // Write side trails the read side by one cycle
  logic [KW-1:0] wk_q, wk_d;
  logic [IW-1:0] wi_q, wi_d;
  logic          wr_pend_q, wr_pend_d;
  assign wr_k = wk_q;
  assign wr_i = wi_q;
`else
  logic [31:0] data_q, data_d;
  assign wr_k = k_q;
  assign wr_i = i_q;
`endif

  assign last_word = (k_q == '0) && (i_q == I_LAST);

  lsp_prev_addr_gen u_addr_gen (
    .rd_k    (k_q),
    .rd_i    (i_q),
    .wr_k    (wr_k),
    .wr_i    (wr_i),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr)
  );

  // State and counter registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      k_q       <= K_FIRST;
      i_q       <= '0;
`ifdef LSP_PREV_UPDATE_PIPE_EN
      wk_q      <= K_FIRST;
      wi_q      <= '0;
      wr_pend_q <= 1'b0;
`else
      data_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
`ifdef LSP_PREV_UPDATE_PIPE_EN
      wk_q      <= wk_d;
      wi_q      <= wi_d;
      wr_pend_q <= wr_pend_d;
`else
      data_q    <= data_d;
`endif
    end
  end

  // Next-state, counter advance and memory port drive
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    i_d          = i_q;
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    done         = 1'b0;
`ifdef LSP_PREV_UPDATE_PIPE_EN
    wk_d         = wk_q;
    wi_d         = wi_q;
    wr_pend_d    = wr_pend_q;

    unique case (state_q)
      StIdle: begin
        wr_pend_d = 1'b0;
        if (start) begin
          state_d = StRead;
          k_d     = K_FIRST;
          i_d     = '0;
        end
      end
      StRead: begin
        memReadAddr = rd_addr;
        // Data for the word read last cycle is on memIn now
        if (wr_pend_q) begin
          memWriteEn   = 1'b1;
          memWriteAddr = wr_addr;
          memOut       = memIn;
        end
        wr_pend_d = 1'b1;
        wk_d      = k_q;
        wi_d      = i_q;
        if (i_q == I_LAST) begin
          i_d = '0;
          if (last_word) begin
            k_d     = K_FIRST;
            state_d = StWrite;
          end else begin
            k_d = k_q - KW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      StWrite: begin
        // Drain the final word
        memWriteEn   = 1'b1;
        memWriteAddr = wr_addr;
        memOut       = memIn;
        wr_pend_d    = 1'b0;
        state_d      = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`else
    data_d = data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          k_d     = K_FIRST;
          i_d     = '0;
        end
      end
      StRead: begin
        memReadAddr = rd_addr;
        state_d     = StWait;
      end
      StWait: begin
        // Capture so the write does not depend on memIn holding past its valid cycle
        data_d  = memIn;
        state_d = StWrite;
      end
      StWrite: begin
        memWriteEn   = 1'b1;
        memWriteAddr = wr_addr;
        memOut       = data_q;
        state_d      = StRead;
        if (i_q == I_LAST) begin
          i_d = '0;
          if (last_word) begin
            k_d     = K_FIRST;
            state_d = StDone;
          end else begin
            k_d = k_q - KW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`endif
  end

endmodule
